// File: rtl/rf_bank_stack.sv
// rf_bank_stack: priority-banked integer register file with a preemption stack.
// Registers selected by SharedMask have one copy shared by all banks. Every
// other register has one copy per priority bank. Each banked copy has a valid
// bit, and an invalid copy reads as zero, which makes bank clearing on
// interrupt entry a single-cycle operation.
// Interrupt entry pushes the active level onto an internal stack. Exit pops it.
// Asserting entry and exit together tail-chains into a new level without
// touching the stack.
// There is no valid/ready handshake here: reads are combinational from
// registered state, and entry/exit/write are single-cycle pulses sampled at
// the rising clock edge.
// Debug visibility: the control state (active level, depth, sticky error) is
// exported directly on cur_level_o, depth_o and err_o.
// level_i is assumed to be below PrioNum.
module rf_bank_stack #(
  parameter int PrioNum = 8,
  parameter int RegNum = 32,
  parameter int DataWidth = 32,
  parameter logic [RegNum-1:0] SharedMask = RegNum'(32'h0000_0004),
  parameter logic [DataWidth-1:0] RaValue = DataWidth'(32'hFFFF_FFFF),
  localparam int PrioWidth = $clog2(PrioNum),
  localparam int AddrWidth = $clog2(RegNum)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_i,
  input  logic                 exit_i,
  input  logic [PrioWidth-1:0] level_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr1_i,
  input  logic [AddrWidth-1:0] raddr2_i,
  output logic [DataWidth-1:0] rdata1_o,
  output logic [DataWidth-1:0] rdata2_o,
  output logic [DataWidth-1:0] sp_o,
  output logic [PrioWidth-1:0] cur_level_o,
  output logic [PrioWidth-1:0] depth_o,
  output logic                 err_o
);

  // Storage. Only the SharedMask entries of r_shared are used. Only the
  // non-shared entries of r_bank and r_valid are used.
  logic [DataWidth-1:0] r_shared [RegNum];
  logic [DataWidth-1:0] r_bank   [PrioNum][RegNum];
  logic [RegNum-1:0]    r_valid  [PrioNum];

  // Preemption stack of saved levels. r_depth is the number of entries in use.
  logic [PrioWidth-1:0] r_stack [PrioNum-1];
  logic [PrioWidth-1:0] r_cur;
  logic [PrioWidth-1:0] r_depth;
  logic                 r_err;

  logic [PrioWidth-1:0] w_top_idx;
  logic [PrioWidth-1:0] w_top;
  logic                 w_entry_ok;
  logic                 w_exit_ok;
  logic                 w_tail_ok;
  logic                 w_bad;
  logic                 w_new_bank;

  // Read view of one architectural register under the active bank.
  function automatic logic [DataWidth-1:0] f_read(input logic [AddrWidth-1:0] a);
    f_read = '0;
    if (a != '0) begin
      if (SharedMask[a]) begin
        f_read = r_shared[a];
      end else if (r_valid[r_cur][a]) begin
        f_read = r_bank[r_cur][a];
      end
    end
  endfunction

  // Classify this cycle's entry/exit/tail-chain request as legal or illegal.
  always_comb begin
    w_top_idx  = '0;
    w_top      = '0;
    w_entry_ok = 1'b0;
    w_exit_ok  = 1'b0;
    w_tail_ok  = 1'b0;
    w_bad      = 1'b0;
    if (r_depth != '0) begin
      w_top_idx = r_depth - 1'b1;
    end
    w_top = r_stack[w_top_idx];
    if (entry_i && !exit_i) begin
      w_entry_ok = (level_i > r_cur);
      w_bad      = !w_entry_ok;
    end else if (exit_i && !entry_i) begin
      w_exit_ok = (r_depth != '0);
      w_bad     = !w_exit_ok;
    end else if (entry_i && exit_i) begin
      w_tail_ok = (r_depth != '0) && (level_i > w_top);
      w_bad     = !w_tail_ok;
    end
    w_new_bank = w_entry_ok | w_tail_ok;
  end

  // Combinational read ports; no bypass of a same-cycle write.
  always_comb begin
    rdata1_o = f_read(raddr1_i);
    rdata2_o = f_read(raddr2_i);
    sp_o     = f_read(AddrWidth'(2));
  end

  assign cur_level_o = r_cur;
  assign depth_o     = r_depth;
  assign err_o       = r_err;

  // Register storage: the write goes to the current bank. On a legal entry or
  // tail-chain the new bank is invalidated and gets ra. The entry update is
  // placed last, so it wins if a tail-chain re-enters the current bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < RegNum; r++) begin
        r_shared[r] <= '0;
      end
      for (int p = 0; p < PrioNum; p++) begin
        r_valid[p] <= '1;
        for (int r = 0; r < RegNum; r++) begin
          r_bank[p][r] <= '0;
        end
      end
    end else begin
      if (we_i && (waddr_i != '0)) begin
        if (SharedMask[waddr_i]) begin
          r_shared[waddr_i] <= wdata_i;
        end else begin
          r_bank[r_cur][waddr_i]  <= wdata_i;
          r_valid[r_cur][waddr_i] <= 1'b1;
        end
      end
      if (w_new_bank) begin
        r_valid[level_i] <= RegNum'(2);
        if (SharedMask[1]) begin
          r_shared[1] <= RaValue;
        end else begin
          r_bank[level_i][1] <= RaValue;
        end
      end
    end
  end

  // Level, depth, stack and sticky error updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur   <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < PrioNum - 1; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      if (w_entry_ok) begin
        r_stack[r_depth] <= r_cur;
        r_depth          <= r_depth + 1'b1;
        r_cur            <= level_i;
      end else if (w_exit_ok) begin
        r_depth <= r_depth - 1'b1;
        r_cur   <= w_top;
      end else if (w_tail_ok) begin
        r_cur <= level_i;
      end
      if (w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rf_bank_stack.md
# rf_bank_stack

Parametrised, priority-banked integer register file with a hardware preemption stack. It replaces a fixed per-priority register file array with configurable bank count, register count, width and shared-register mask. It adds an internal nesting stack driven by interrupt entry/exit pulses, per-bank lazy clearing through valid bits, and sticky error reporting. It sits between decode/writeback and the interrupt controller in the core.

## Interface
Parameters:
- PrioNum, 8: number of priority levels/banks; PrioWidth = $clog2(PrioNum)
- RegNum, 32: architectural registers per view; AddrWidth = $clog2(RegNum)
- DataWidth, 32: register width
- SharedMask, 32'h0000_0004: bit r=1 means register r has a single copy shared by all banks (default: only x2/sp); bit 0 ignored
- RaValue, 32'hFFFF_FFFF: value written into x1/ra of the entered bank on interrupt entry

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- entry_i  input  1  interrupt entry pulse (one cycle)
- exit_i  input  1  interrupt return pulse (one cycle)
- level_i  input  PrioWidth  priority of the interrupt being entered, sampled with entry_i
- we_i  input  1  write enable
- waddr_i  input  AddrWidth  write address
- wdata_i  input  DataWidth  write data
- raddr1_i, raddr2_i  input  AddrWidth  read addresses
- rdata1_o, rdata2_o  output  DataWidth  read data, combinational
- sp_o  output  DataWidth  current view of x2
- cur_level_o  output  PrioWidth  active bank
- depth_o  output  PrioWidth  nesting depth (0 = thread mode)
- err_o  output  1  sticky protocol error

## Operation
- State: shared copies for SharedMask registers; PrioNum banks of the others; per-bank valid bit per banked register; level stack of PrioNum-1 entries; cur_level; depth; err.
- x0: reads 0, writes ignored.
- Reads: shared reg → shared copy. Banked reg → bank[cur_level] if valid, else 0. Read reflects registered state only; no write bypass.
- Writes with we_i: shared reg → shared copy. Banked reg → bank[cur_level] and set its valid bit. Writes always use cur_level before any same-cycle level change.
- Entry (entry_i & !exit_i):
  - legal iff level_i > cur_level: push cur_level, depth+1, cur_level ← level_i
  - in the new bank: clear all valid bits except x1, write ra ← RaValue
- Exit (exit_i & !entry_i):
  - legal iff depth>0: pop into cur_level, depth−1
  - the popped-to bank's contents are untouched
- Tail-chain (entry_i & exit_i):
  - legal iff depth>0 and level_i > stack top (saved level)
  - cur_level ← level_i, depth unchanged
  - new bank cleared/ra set as for entry
- Illegal entry, exit or tail-chain: no state change except err ← 1. Write still performed.
- Entry whose bank equals a bank below on the stack cannot occur legally, because levels strictly increase.

## Timing
- Reset (async assert): all registers 0, all valid bits 1, cur_level_o=0, depth_o=0, err_o=0, rdata/sp_o=0.
- Deassertion is synchronous to the first clk edge; reset asserted mid-nesting abandons the stack entirely.
- Entry/exit/tail-chain take effect at the edge where they are sampled. Reads in the following cycle use the new bank: one cycle latency, matching the core's registered level.
- Write latency: data readable the cycle after we_i.
- err_o stays high until reset.

## Test plan
- Reset, then read x1..x31 → all 0; cur_level_o=0, depth_o=0, err_o=0.
- Level 0: write x5=0x1234, x2=0x8000. Entry level 3. Next cycle: x5 reads 0, x1 reads 0xFFFF_FFFF, sp_o=0x8000, depth_o=1. Exit. Next cycle: x5 reads 0x1234, x1 reads 0.
- Nest 0→2→5. Write x10 at each level. Exit twice → each bank's x10 restored in order. Third exit → err_o=1, cur_level_o=0, depth_o=0.
- At level 4: entry level 4 (not higher) → err_o=1, level unchanged. Entry level 2 → likewise ignored.
- Nest 0→1→3, then simultaneous entry(6)+exit → cur_level_o=6, depth_o=2, x1=RaValue. Exit → cur_level_o=1.
- Write x7=0xAA in the same cycle as entry(2) from level 0. Exit later → x7=0xAA in bank 0; bank 2 x7 read 0.
- Assert reset while depth_o=3 → all outputs return to reset values immediately.
